vga_bram_reader: RTL and testbench

- Downstream consumer of the frame-buffer BRAM.
- Generates 640x480@60 VGA timing from a pixel clock-enable derived from sysclk (100 MHz / 4 = 25 MHz).
- Drives the BRAM read address in raster order and re-aligns the returned RGB444 data with delayed sync/blank so the pixel and its syncs leave on the same tick.
- Replaces the separately clocked VGA path with a single-clock design; the BRAM read port runs on sysclk.

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_timing_gen.sv | 99 +++++++++
 rtl/vga_bram_reader.sv | 133 +++++++++++++
 tb/tb_vga_bram_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA frame-buffer reader: default 640x480@60 timing,
// RGB444 width, colour-bar palette and the sync/blank bundle carried down the delay line.
package vga_pkg;

    localparam int H_TOT    = 800;
    localparam int V_TOT    = 525;
    localparam int HS_START = 656;
    localparam int HS_END   = 751;
    localparam int VS_START = 490;
    localparam int VS_END   = 491;
    localparam int FB_DEPTH = 307200;

    localparam int RGB_W = 12;

    localparam logic [RGB_W-1:0] COL_WHITE   = 12'hFFF;
    localparam logic [RGB_W-1:0] COL_YELLOW  = 12'hFF0;
    localparam logic [RGB_W-1:0] COL_CYAN    = 12'h0FF;
    localparam logic [RGB_W-1:0] COL_GREEN   = 12'h0F0;
    localparam logic [RGB_W-1:0] COL_MAGENTA = 12'hF0F;
    localparam logic [RGB_W-1:0] COL_RED     = 12'hF00;
    localparam logic [RGB_W-1:0] COL_BLUE    = 12'h00F;
    localparam logic [RGB_W-1:0] COL_BLACK   = 12'h000;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

    function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel clock-enable divider, raster h/v counters, undelayed de/hs/vs and frame_start.
// With VGA_TEST_PATTERN_EN it also tracks the colour-bar index for the current h.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic       sysclk,
    input  logic       sysrst,
    output logic       pix_ce,
    output logic       frame_start,
`ifdef VGA_TEST_PATTERN_EN
    output logic [2:0] bar_idx,
`endif
    output logic       de0,
    output logic       hs0,
    output logic       vs0
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, v_wrap;

    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst)
            div_cnt <= '0;
        else if (div_cnt == DW'(CLK_DIV - 1))
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign pix_ce = (div_cnt == DW'(CLK_DIV - 1));
    assign h_wrap = (h_cnt == HW'(HT - 1));
    assign v_wrap = (v_cnt == VW'(VT - 1));

    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Fires on the tick that moves the raster back to h=0, v=0.
    assign frame_start = pix_ce && h_wrap && v_wrap;

    assign de0 = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hs0 = !((h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                   (h_cnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1)));
    assign vs0 = !((v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                   (v_cnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1)));

`ifdef VGA_TEST_PATTERN_EN
    // Bar width need not be a power of two, so count pixels within a bar instead of dividing h.
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [BW-1:0] bar_px;

    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (pix_ce) begin
            if (h_wrap) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_px == BW'(BAR_W - 1)) begin
                bar_px <= '0;
                if (bar_idx != 3'd7)
                    bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/vga_bram_reader.sv
// Frame-buffer BRAM reader: raster address generation, RD_LAT-deep sync/blank delay line
// and registered RGB444/HS/VS outputs. Optional colour bars under VGA_TEST_PATTERN_EN.
module vga_bram_reader
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LAT   = 1,
    parameter int ADDR_W   = 19
) (
    input  logic              sysclk,
    input  logic              sysrst,
    input  logic [11:0]       pixel_data,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_pattern_sel,
`endif
    output logic [ADDR_W-1:0] bram_read_addr,
    output logic              pix_ce,
    output logic              frame_start,
    output logic [3:0]        vga_out_r,
    output logic [3:0]        vga_out_g,
    output logic [3:0]        vga_out_b,
    output logic              vga_out_hs,
    output logic              vga_out_vs
);

    localparam int FB_WORDS = H_ACTIVE * V_ACTIVE;

    logic              de0, hs0, vs0;
    logic [ADDR_W-1:0] addr_cnt;
    sync_t [RD_LAT-1:0] sync_pipe;
    logic [RGB_W-1:0]  pix_src;
    logic [RGB_W-1:0]  rgb;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]                    bar_idx;
    logic [RD_LAT-1:0][RGB_W-1:0]  pat_pipe;
`endif

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_ACTIVE(V_ACTIVE),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .sysclk     (sysclk),
        .sysrst     (sysrst),
        .pix_ce     (pix_ce),
        .frame_start(frame_start),
`ifdef VGA_TEST_PATTERN_EN
        .bar_idx    (bar_idx),
`endif
        .de0        (de0),
        .hs0        (hs0),
        .vs0        (vs0)
    );

    // Linear address counter; wraps after the last visible pixel so it never leaves the buffer.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            addr_cnt       <= '0;
            bram_read_addr <= '0;
        end else if (pix_ce) begin
            if (frame_start) begin
                addr_cnt <= '0;
            end else if (de0) begin
                bram_read_addr <= addr_cnt;
                addr_cnt <= (addr_cnt == ADDR_W'(FB_WORDS - 1)) ? '0 : addr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            for (int i = 0; i < RD_LAT; i++)
                sync_pipe[i] <= SYNC_IDLE;
        end else if (pix_ce) begin
            sync_pipe[0] <= '{de: de0, hs: hs0, vs: vs0};
            for (int i = 1; i < RD_LAT; i++)
                sync_pipe[i] <= sync_pipe[i-1];
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            pat_pipe <= '0;
        end else if (pix_ce) begin
            pat_pipe[0] <= bar_colour(bar_idx);
            for (int i = 1; i < RD_LAT; i++)
                pat_pipe[i] <= pat_pipe[i-1];
        end
    end
`endif

    always_comb begin
        pix_src = pixel_data;
`ifdef VGA_TEST_PATTERN_EN
        if (test_pattern_sel)
            pix_src = pat_pipe[RD_LAT-1];
`endif
    end

    // Output stage: BRAM data for an address lands together with that pixel's delayed syncs.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            rgb        <= '0;
            vga_out_hs <= 1'b1;
            vga_out_vs <= 1'b1;
        end else if (pix_ce) begin
            rgb        <= sync_pipe[RD_LAT-1].de ? pix_src : '0;
            vga_out_hs <= sync_pipe[RD_LAT-1].hs;
            vga_out_vs <= sync_pipe[RD_LAT-1].vs;
        end
    end

    assign vga_out_r = rgb[11:8];
    assign vga_out_g = rgb[7:4];
    assign vga_out_b = rgb[3:0];

endmodule

// File: tb/tb_vga_bram_reader.sv
// Directed bench: full 640x480 instance for line timing/addressing, plus two scaled-down
// instances (16x4 visible, RD_LAT=1 and 2) for frame, alignment and mid-frame reset.
module tb_vga_bram_reader;

    logic sysclk = 1'b0;
    logic sysrst;
    logic tps;

    always #5 sysclk = ~sysclk;

    // full-size instance
    logic [18:0] addr_f;
    logic [11:0] pd_f;
    logic        pce_f, fs_f, hs_f, vs_f;
    logic [3:0]  r_f, g_f, b_f;
    // scaled instance, RD_LAT=1
    logic [18:0] addr_s;
    logic [11:0] pd_s;
    logic        pce_s, fs_s, hs_s, vs_s;
    logic [3:0]  r_s, g_s, b_s;
    // scaled instance, RD_LAT=2
    logic [18:0] addr_s2;
    logic [11:0] pd_s2;
    logic        pce_s2, fs_s2, hs_s2, vs_s2;
    logic [3:0]  r_s2, g_s2, b_s2;

    vga_bram_reader u_full (
        .sysclk(sysclk), .sysrst(sysrst), .pixel_data(pd_f),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern_sel(1'b0),
`endif
        .bram_read_addr(addr_f), .pix_ce(pce_f), .frame_start(fs_f),
        .vga_out_r(r_f), .vga_out_g(g_f), .vga_out_b(b_f),
        .vga_out_hs(hs_f), .vga_out_vs(vs_f)
    );

    vga_bram_reader #(
        .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LAT(1), .ADDR_W(19)
    ) u_s (
        .sysclk(sysclk), .sysrst(sysrst), .pixel_data(pd_s),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern_sel(tps),
`endif
        .bram_read_addr(addr_s), .pix_ce(pce_s), .frame_start(fs_s),
        .vga_out_r(r_s), .vga_out_g(g_s), .vga_out_b(b_s),
        .vga_out_hs(hs_s), .vga_out_vs(vs_s)
    );

    vga_bram_reader #(
        .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LAT(2), .ADDR_W(19)
    ) u_s2 (
        .sysclk(sysclk), .sysrst(sysrst), .pixel_data(pd_s2),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern_sel(1'b0),
`endif
        .bram_read_addr(addr_s2), .pix_ce(pce_s2), .frame_start(fs_s2),
        .vga_out_r(r_s2), .vga_out_g(g_s2), .vga_out_b(b_s2),
        .vga_out_hs(hs_s2), .vga_out_vs(vs_s2)
    );

    // BRAM models: data = addr[11:0]; 1 sysclk latency, or one pixel tick per extra stage.
    always @(posedge sysclk) begin
        pd_f <= addr_f[11:0];
        pd_s <= addr_s[11:0];
        if (pce_s2) pd_s2 <= addr_s2[11:0];
    end

    int errors = 0;
    int checks = 0;
    int tk, cyc;

    // window m = negedge where pix_ce is high for tick m (counters at raster position m)
    logic [18:0] a_s [0:400];
    logic [11:0] c_s [0:400];
    logic [11:0] c_s2[0:400];
    logic        h_s [0:400];
    logic        h_s2[0:400];
    logic        v_s [0:400];
    logic        f_s [0:400];
    logic        h_fr[0:1500];
    logic [18:0] a_fr[0:1500];
    logic [11:0] c_fr[0:1500];
    int          cyc_r[0:1500];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_tick();
        int n = 0;
        do begin
            @(negedge sysclk);
            cyc++;
            n++;
        end while (!pce_s && n < 16);
        if (!pce_s) chk("tick_timeout", 32'(pce_s), 32'd1);
        tk++;
    endtask

    task automatic rec();
        if (tk >= 0 && tk <= 400) begin
            a_s[tk]  = addr_s;
            c_s[tk]  = {r_s, g_s, b_s};
            c_s2[tk] = {r_s2, g_s2, b_s2};
            h_s[tk]  = hs_s;
            h_s2[tk] = hs_s2;
            v_s[tk]  = vs_s;
            f_s[tk]  = fs_s;
        end
        if (tk >= 0 && tk <= 1500) begin
            h_fr[tk]  = hs_f;
            a_fr[tk]  = addr_f;
            c_fr[tk]  = {r_f, g_f, b_f};
            cyc_r[tk] = cyc;
        end
    endtask

    initial begin
        logic [2:0] ce_seq;
        int f1, r1, f2, cnt, amax;

        sysrst = 1'b1;
        tps    = 1'b0;
        cyc    = 0;
        tk     = -1;

        // reset / idle
        repeat (10) @(negedge sysclk);
        chk("rst_full_out", {16'h0, r_f, g_f, b_f, hs_f, vs_f, pce_f, fs_f}, {16'h0, 12'h000, 4'b1100});
        chk("rst_full_addr", 32'(addr_f), 32'd0);
        chk("rst_small_out", {r_s2, g_s2, b_s2, hs_s2, vs_s2, pce_s2, fs_s2, 19'(addr_s2)},
                             {12'h000, 4'b1100, 19'd0});

        sysrst = 1'b0;
        @(negedge sysclk); ce_seq[2] = pce_f;
        @(negedge sysclk); ce_seq[1] = pce_f;
        @(negedge sysclk); ce_seq[0] = pce_f;
        chk("first_pix_ce", 32'(ce_seq), 32'b001);
        cyc = 3;
        tk  = 0;
        rec();

        for (int m = 1; m <= 1500; m++) begin
            step_tick();
            rec();
        end

        // full-size line timing and addressing
        f1 = -1; r1 = -1; f2 = -1;
        for (int m = 0; m <= 1500; m++) begin
            if (f1 < 0 && !h_fr[m]) f1 = m;
            else if (f1 >= 0 && r1 < 0 && h_fr[m]) r1 = m;
            else if (r1 >= 0 && f2 < 0 && !h_fr[m]) f2 = m;
        end
        chk("hs_fall_window", 32'(f1), 32'd658);
        chk("hs_low_sysclk", (f1 >= 0 && r1 >= 0) ? 32'(cyc_r[r1] - cyc_r[f1]) : 32'hFFFFFFFF, 32'd384);
        chk("line_period_sysclk", (f1 >= 0 && f2 >= 0) ? 32'(cyc_r[f2] - cyc_r[f1]) : 32'hFFFFFFFF, 32'd3200);
        chk("full_addr_639", 32'(a_fr[640]), 32'd639);
        chk("full_addr_blank_hold", 32'(a_fr[700]), 32'd639);
        chk("full_addr_line1", 32'(a_fr[801]), 32'd640);
        chk("full_rgb_px5", 32'(c_fr[7]), 32'h005);
        chk("full_rgb_px639", 32'(c_fr[641]), 32'h27F);
        chk("full_rgb_blank", 32'(c_fr[642]), 32'h000);

        // scaled frame: addressing
        chk("s_addr_0", 32'(a_s[1]), 32'd0);
        chk("s_addr_5", 32'(a_s[6]), 32'd5);
        chk("s_addr_blank_hold", 32'(a_s[20]), 32'd15);
        chk("s_addr_line1", 32'(a_s[25]), 32'd16);
        chk("s_addr_last", 32'(a_s[88]), 32'd63);
        chk("s_addr_vblank_hold", 32'(a_s[150]), 32'd63);
        chk("s_addr_next_frame", 32'(a_s[193]), 32'd0);
        chk("s_addr_next_frame1", 32'(a_s[194]), 32'd1);
        amax = 0;
        for (int m = 0; m <= 400; m++) if (int'(a_s[m]) > amax) amax = int'(a_s[m]);
        chk("s_addr_max", 32'(amax), 32'd63);

        // scaled frame: alignment RD_LAT=1
        chk("s_rgb_px0", 32'(c_s[2]), 32'h000);
        chk("s_rgb_px5", 32'(c_s[7]), 32'h005);
        chk("s_rgb_px15", 32'(c_s[17]), 32'h00F);
        chk("s_rgb_blank", 32'(c_s[18]), 32'h000);
        chk("s_rgb_line1_px1", 32'(c_s[27]), 32'h011);
        chk("s_rgb_last", 32'(c_s[89]), 32'h03F);
        // alignment RD_LAT=2
        chk("s2_rgb_px0", 32'(c_s2[3]), 32'h000);
        chk("s2_rgb_px5", 32'(c_s2[8]), 32'h005);
        chk("s2_rgb_px15", 32'(c_s2[18]), 32'h00F);
        chk("s2_rgb_blank", 32'(c_s2[19]), 32'h000);
        chk("s2_hs_edge", {30'h0, h_s2[20], h_s2[21]}, 32'b10);

        // scaled syncs and frame_start
        chk("s_hs_edges", {28'h0, h_s[19], h_s[20], h_s[23], h_s[24]}, 32'b1001);
        cnt = 0;
        for (int m = 2; m <= 25; m++) if (!h_s[m]) cnt++;
        chk("s_hs_width", 32'(cnt), 32'd4);
        chk("s_vs_edges", {28'h0, v_s[121], v_s[122], v_s[169], v_s[170]}, 32'b1001);
        chk("s_frame_start_tick", 32'(f_s[191]), 32'd1);
        cnt = 0;
        for (int m = 0; m <= 383; m++) if (f_s[m]) cnt++;
        chk("s_frame_start_count", 32'(cnt), 32'd2);

        // mid-frame reset at scaled line 2, h=10
        while (tk < 1594) step_tick();
        chk("pre_reset_addr", 32'(addr_s), 32'd41);
        chk("pre_reset_rgb", 32'({r_s, g_s, b_s}), 32'h028);
        sysrst = 1'b1;
        #1;
        chk("midrst_out", {r_s, g_s, b_s, hs_s, vs_s, pce_s, fs_s, 19'(addr_s)},
                          {12'h000, 4'b1100, 19'd0});
        repeat (3) @(negedge sysclk);
        sysrst = 1'b0;
        tk = -1;
        step_tick();
        tps = 1'b1;
        while (tk < 2) step_tick();
        chk("restart_addr", 32'(addr_s), 32'd1);
        while (tk < 4) step_tick();
`ifdef VGA_TEST_PATTERN_EN
        chk("pattern_bar1", 32'({r_s, g_s, b_s}), 32'hFF0);
        while (tk < 7) step_tick();
        chk("pattern_bar2", 32'({r_s, g_s, b_s}), 32'h0FF);
        while (tk < 17) step_tick();
        chk("pattern_bar7", 32'({r_s, g_s, b_s}), 32'h000);
`else
        chk("restart_rgb_px2", 32'({r_s, g_s, b_s}), 32'h002);
        while (tk < 7) step_tick();
        chk("restart_rgb_px5", 32'({r_s, g_s, b_s}), 32'h005);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
